alu_result_stage: RTL and testbench

- Registered output stage directly downstream of the ALU's 5-input result-select mux. It captures the selected result, the carry-out/overflow and the 3-bit operation select.
- Computes the zero flag at capture; qualifies carry/overflow by operation; keeps sticky status and a completed-operation counter.
- Uses a valid/ready handshake with a 2-entry skid buffer, so downstream backpressure never drops a result.

---
 rtl/alu_result_stage_if.sv | 44 ++++
 rtl/alu_result_stage.sv | 166 ++++++++++++++++
 tb/tb_alu_result_stage.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_result_stage_if                                       |
// | Purpose  : Handshake and status bundle for the ALU result stage.     |
// |            master = upstream/downstream environment, slave = stage.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface alu_result_stage_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic             in_carryout;
  logic             in_overflow;
  logic [2:0]       in_sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_carryout;
  logic             out_overflow;
  logic [2:0]       out_sel;
  logic             sticky_ovf;
  logic             sticky_illegal;
  logic             clr_sticky;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, in_result, in_carryout, in_overflow, in_sel,
    output out_ready, clr_sticky,
    input  in_ready, out_valid, out_result, out_zero, out_carryout,
    input  out_overflow, out_sel, sticky_ovf, sticky_illegal, op_count
  );

  modport slave (
    input  in_valid, in_result, in_carryout, in_overflow, in_sel,
    input  out_ready, clr_sticky,
    output in_ready, out_valid, out_result, out_zero, out_carryout,
    output out_overflow, out_sel, sticky_ovf, sticky_illegal, op_count
  );
endinterface
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_result_stage                                          |
// | Purpose  : Registered ALU result stage with flag qualification,      |
// |            2-entry skid buffer, sticky status and delivery counter.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_result_stage_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             ovf;
    logic [2:0]       sel;
  } entry_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_ready;
  entry_t           r_main;
  entry_t           r_skid;
  entry_t           w_cap;
  logic             r_sticky_ovf;
  logic             r_sticky_illegal;
  logic [CNT_W-1:0] r_op_count;

  logic w_accept;
  logic w_handoff;
  logic w_illegal;
  logic w_arith;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid;

  assign w_accept  = bus.in_valid && r_in_ready;
  assign w_handoff = (r_state != ST_EMPTY) && bus.out_ready;
  assign w_illegal = (bus.in_sel > 3'd4);
  assign w_arith   = (bus.in_sel == 3'd0) || (bus.in_sel == 3'd1);

  // Build the entry to be stored: illegal selects read as a zero result,
  // carry/overflow are only meaningful for ADD and SUB.
  always_comb begin
    w_cap.result = w_illegal ? '0 : bus.in_result;
    w_cap.zero   = (w_cap.result == '0);
    w_cap.carry  = w_arith && bus.in_carryout;
    w_cap.ovf    = w_arith && bus.in_overflow;
    w_cap.sel    = bus.in_sel;
  end

  // Occupancy state register and registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_TWO);
    end
  end

  // Next occupancy and which register loads from where.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt    = ST_ONE;
          w_load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && !w_handoff) begin
          w_state_nxt = ST_TWO;
          w_load_skid = 1'b1;
        end else if (!w_accept && w_handoff) begin
          w_state_nxt = ST_EMPTY;
        end else if (w_accept && w_handoff) begin
          w_load_main_in = 1'b1;
        end
      end
      ST_TWO: begin
        // ready is low here, so only a handoff can move the state
        if (w_handoff) begin
          w_state_nxt      = ST_ONE;
          w_load_main_skid = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Main and skid data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main <= w_cap;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_cap;
      end
    end
  end

  // Sticky status: a set event in the same cycle beats the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky_ovf     <= 1'b0;
      r_sticky_illegal <= 1'b0;
    end else begin
      if (w_accept && w_cap.ovf) begin
        r_sticky_ovf <= 1'b1;
      end else if (bus.clr_sticky) begin
        r_sticky_ovf <= 1'b0;
      end
      if (w_accept && w_illegal) begin
        r_sticky_illegal <= 1'b1;
      end else if (bus.clr_sticky) begin
        r_sticky_illegal <= 1'b0;
      end
    end
  end

  // Count results handed downstream; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count <= '0;
    end else if (w_handoff) begin
      r_op_count <= r_op_count + 1'b1;
    end
  end

  assign bus.in_ready       = r_in_ready;
  assign bus.out_valid      = (r_state != ST_EMPTY);
  assign bus.out_result     = r_main.result;
  assign bus.out_zero       = r_main.zero;
  assign bus.out_carryout   = r_main.carry;
  assign bus.out_overflow   = r_main.ovf;
  assign bus.out_sel        = r_main.sel;
  assign bus.sticky_ovf     = r_sticky_ovf;
  assign bus.sticky_illegal = r_sticky_illegal;
  assign bus.op_count       = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_alu_result_stage                                       |
// | Purpose  : Directed self-checking bench for alu_result_stage.        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_alu_result_stage;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  alu_result_stage_if #(.WIDTH(32), .CNT_W(16)) bus ();

  alu_result_stage #(.WIDTH(32), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs and checks happen 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [2:0] s,
                       input logic c, input logic o);
    bus.in_valid    = v;
    bus.in_result   = r;
    bus.in_sel      = s;
    bus.in_carryout = c;
    bus.in_overflow = o;
  endtask

  // Pulse reset between edges and release it away from the next edge.
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    bus.out_ready  = 1'b0;
    bus.clr_sticky = 1'b0;
    #12;
    vectors++;
    if ({bus.out_valid, bus.in_ready, bus.out_zero, bus.out_carryout, bus.out_overflow,
         bus.out_sel, bus.sticky_ovf, bus.sticky_illegal} !== 10'b01_000_000_00) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected %b",
               {bus.out_valid, bus.in_ready, bus.out_zero, bus.out_carryout, bus.out_overflow,
                bus.out_sel, bus.sticky_ovf, bus.sticky_illegal}, 10'b01_000_000_00);
    end
    vectors++;
    if (bus.out_result !== 32'h0 || bus.op_count !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_data: got result=%h count=%0d expected 0/0",
               bus.out_result, bus.op_count);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_op();
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h5, 3'd0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    vectors++;
    if ({bus.out_valid, bus.out_zero, bus.out_carryout, bus.out_overflow, bus.out_sel} !== 7'b1010_000
        || bus.out_result !== 32'h5) begin
      miscompares++;
      $display("FAIL single_op: got v/z/c/o/sel=%b result=%h expected 1010000 / 00000005",
               {bus.out_valid, bus.out_zero, bus.out_carryout, bus.out_overflow, bus.out_sel},
               bus.out_result);
    end
    tick();
    vectors++;
    if (bus.op_count !== 16'd1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_count: got count=%0d valid=%b expected 1 / 0",
               bus.op_count, bus.out_valid);
    end
  endtask

  task automatic test_qualify();
    drive(1'b1, 32'h55, 3'd2, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    vectors++;
    if ({bus.out_carryout, bus.out_overflow, bus.sticky_ovf} !== 3'b000) begin
      miscompares++;
      $display("FAIL qual_xor: got c/o/sticky=%b expected 000",
               {bus.out_carryout, bus.out_overflow, bus.sticky_ovf});
    end
    tick();
    drive(1'b1, 32'h7, 3'd1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    vectors++;
    if ({bus.out_overflow, bus.sticky_ovf, bus.out_sel} !== 5'b11_001) begin
      miscompares++;
      $display("FAIL qual_sub: got o/sticky/sel=%b expected 11001",
               {bus.out_overflow, bus.sticky_ovf, bus.out_sel});
    end
    tick();
    bus.clr_sticky = 1'b1;
    tick();
    bus.clr_sticky = 1'b0;
    vectors++;
    if (bus.sticky_ovf !== 1'b0 || bus.op_count !== 16'd3) begin
      miscompares++;
      $display("FAIL qual_clear: got sticky=%b count=%0d expected 0 / 3",
               bus.sticky_ovf, bus.op_count);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hA, 3'd0, 1'b0, 1'b0);
    tick();
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_result !== 32'hA) begin
      miscompares++;
      $display("FAIL bp_first: got ready=%b result=%h expected 1 / 0000000a",
               bus.in_ready, bus.out_result);
    end
    drive(1'b1, 32'hB, 3'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hC, 3'd0, 1'b0, 1'b0);
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.out_result !== 32'hA || bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_full: got ready=%b valid=%b result=%h expected 0 / 1 / 0000000a",
               bus.in_ready, bus.out_valid, bus.out_result);
    end
    tick();
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.out_result !== 32'hA) begin
      miscompares++;
      $display("FAIL bp_hold: got ready=%b result=%h expected 0 / 0000000a",
               bus.in_ready, bus.out_result);
    end
    bus.out_ready = 1'b1;
    tick();
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_result !== 32'hB || bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_drain_b: got ready=%b valid=%b result=%h expected 1 / 1 / 0000000b",
               bus.in_ready, bus.out_valid, bus.out_result);
    end
    tick();
    drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    vectors++;
    if (bus.out_result !== 32'hC || bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_drain_c: got valid=%b result=%h expected 1 / 0000000c",
               bus.out_valid, bus.out_result);
    end
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.op_count !== 16'd6) begin
      miscompares++;
      $display("FAIL bp_empty: got valid=%b count=%0d expected 0 / 6",
               bus.out_valid, bus.op_count);
    end
  endtask

  task automatic test_zero_illegal();
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h0, 3'd3, 1'b1, 1'b1);
    tick();
    vectors++;
    if ({bus.out_zero, bus.out_carryout, bus.out_overflow} !== 3'b100 || bus.out_result !== 32'h0) begin
      miscompares++;
      $display("FAIL slt_zero: got z/c/o=%b result=%h expected 100 / 00000000",
               {bus.out_zero, bus.out_carryout, bus.out_overflow}, bus.out_result);
    end
    drive(1'b1, 32'h1234, 3'd6, 1'b0, 1'b0);
    tick();
    vectors++;
    if (bus.out_result !== 32'h0 || {bus.out_zero, bus.sticky_illegal, bus.out_sel} !== 5'b11_110) begin
      miscompares++;
      $display("FAIL illegal: got result=%h z/sticky/sel=%b expected 00000000 / 11110",
               bus.out_result, {bus.out_zero, bus.sticky_illegal, bus.out_sel});
    end
    drive(1'b1, 32'h99, 3'd7, 1'b0, 1'b0);
    bus.clr_sticky = 1'b1;
    tick();
    drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    vectors++;
    if (bus.sticky_illegal !== 1'b1 || bus.out_result !== 32'h0) begin
      miscompares++;
      $display("FAIL clr_vs_set: got sticky=%b result=%h expected 1 / 00000000",
               bus.sticky_illegal, bus.out_result);
    end
    tick();
    bus.clr_sticky = 1'b0;
    vectors++;
    if (bus.sticky_illegal !== 1'b0 || bus.op_count !== 16'd9) begin
      miscompares++;
      $display("FAIL clr_only: got sticky=%b count=%0d expected 0 / 9",
               bus.sticky_illegal, bus.op_count);
    end
  endtask

  task automatic test_streaming();
    pulse_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h100 + 32'(i), 3'd4, 1'b0, 1'b0);
      tick();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || bus.out_result !== 32'h100 + 32'(i)) begin
        miscompares++;
        $display("FAIL stream_%0d: got valid=%b ready=%b result=%h expected 1 / 1 / %h",
                 i, bus.out_valid, bus.in_ready, bus.out_result, 32'h100 + 32'(i));
      end
    end
    drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    tick();
    vectors++;
    if (bus.op_count !== 16'd10 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_count: got count=%0d valid=%b expected 10 / 0",
               bus.op_count, bus.out_valid);
    end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hDEAD, 3'd0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'hBEEF, 3'd0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.op_count !== 16'd10 || bus.sticky_ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset: got ready=%b count=%0d sticky=%b expected 0 / 10 / 1",
               bus.in_ready, bus.op_count, bus.sticky_ovf);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.out_valid, bus.in_ready, bus.sticky_ovf} !== 3'b010 || bus.op_count !== 16'd0) begin
      miscompares++;
      $display("FAIL async_reset: got v/r/sticky=%b count=%0d expected 010 / 0",
               {bus.out_valid, bus.in_ready, bus.sticky_ovf}, bus.op_count);
    end
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.op_count !== 16'd0) begin
        miscompares++;
        $display("FAIL stale_%0d: got valid=%b count=%0d expected 0 / 0",
                 i, bus.out_valid, bus.op_count);
      end
    end
    drive(1'b1, 32'h42, 3'd0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h42) begin
      miscompares++;
      $display("FAIL post_reset_op: got valid=%b result=%h expected 1 / 00000042",
               bus.out_valid, bus.out_result);
    end
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_single_op();
    test_qualify();
    test_backpressure();
    test_zero_illegal();
    test_streaming();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
